// File: rtl/text_console_pkg.sv
// Shared constants, control codes and state encoding for the text console.
// Geometry is fixed at 80x30 so the 5/7/12-bit port widths always fit.
package text_console_pkg;

    localparam int COLS = 80;
    localparam int ROWS = 30;
    localparam logic [7:0] BLANK = 8'h20;

    localparam logic [6:0]  LAST_COL     = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW     = 5'(ROWS - 1);
    localparam logic [11:0] LINE_CELLS   = 12'(COLS);
    localparam logic [11:0] SCREEN_CELLS = 12'(COLS * ROWS);

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLR_LINE,
        ST_CLR_SCREEN
    } state_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c != 8'h7F);
    endfunction

endpackage

// File: rtl/text_console_blank_filler.sv
// Streams BLANK writes over a contiguous address range, then pulses done.
// Comes out of reset already clearing the whole screen.
module text_console_blank_filler
    import text_console_pkg::*;
(
    input  logic        CPUClk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] base,
    input  logic [11:0] count,
    output logic        fill_valid,
    output logic [11:0] fill_addr,
    output logic        done
);

    logic        active;
    logic        last;
    logic [11:0] cnt;
    logic [11:0] fill_base;
    logic [11:0] fill_count;

    assign fill_valid = active;
    assign fill_addr  = fill_base + cnt;
    assign last       = active && (cnt == fill_count - 12'd1);

    // done lags the final write by one cycle so the owner reopens a cycle later
    always_ff @(posedge CPUClk or posedge reset) begin
        if (reset) begin
            active     <= 1'b1;
            cnt        <= '0;
            fill_base  <= '0;
            fill_count <= SCREEN_CELLS;
            done       <= 1'b0;
        end else begin
            done <= last;
            if (start) begin
                active     <= 1'b1;
                cnt        <= '0;
                fill_base  <= base;
                fill_count <= count;
            end else if (active) begin
                cnt <= cnt + 12'd1;
                if (last) begin
                    active <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/text_console.sv
// CPU byte stream to character-RAM writer: cursor, control codes and
// wrap-and-clear scrolling for an 80x30 text screen.
module text_console
    import text_console_pkg::*;
(
    input  logic        CPUClk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [4:0]  cursor_row,
    output logic [6:0]  cursor_col
);

    state_t      state;
    state_t      state_next;
    logic [11:0] line_base;
    logic [11:0] base_next;
    logic [4:0]  row_next;
    logic [6:0]  col_next;
    logic        accept;
    logic        adv;
    logic        wr_next;
    logic [11:0] addr_next;
    logic [7:0]  data_next;
    logic [11:0] cur_addr;

    logic        fill_start;
    logic [11:0] fill_base_in;
    logic [11:0] fill_count_in;
    logic        fill_valid;
    logic [11:0] fill_addr;
    logic        fill_done;

    assign accept   = in_valid && in_ready;
    assign cur_addr = line_base + {5'd0, cursor_col};

    text_console_blank_filler u_blank_filler (
        .CPUClk     (CPUClk),
        .reset      (reset),
        .start      (fill_start),
        .base       (fill_base_in),
        .count      (fill_count_in),
        .fill_valid (fill_valid),
        .fill_addr  (fill_addr),
        .done       (fill_done)
    );

    always_ff @(posedge CPUClk or posedge reset) begin
        if (reset) begin
            state <= ST_CLR_SCREEN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        row_next      = cursor_row;
        col_next      = cursor_col;
        base_next     = line_base;
        adv           = 1'b0;
        wr_next       = 1'b0;
        addr_next     = cur_addr;
        data_next     = in_data;
        fill_start    = 1'b0;
        fill_base_in  = '0;
        fill_count_in = LINE_CELLS;

        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_printable(in_data)) begin
                        wr_next = 1'b1;
                        if (cursor_col == LAST_COL) begin
                            col_next = '0;
                            adv      = 1'b1;
                        end else begin
                            col_next = cursor_col + 7'd1;
                        end
                    end else if (in_data == CH_LF) begin
                        adv = 1'b1;
                    end else if (in_data == CH_CR) begin
                        col_next = '0;
                    end else if (in_data == CH_BS) begin
                        if (cursor_col != '0) begin
                            col_next  = cursor_col - 7'd1;
                            wr_next   = 1'b1;
                            addr_next = cur_addr - 12'd1;
                            data_next = BLANK;
                        end
                    end else if (in_data == CH_FF) begin
                        row_next      = '0;
                        col_next      = '0;
                        base_next     = '0;
                        fill_start    = 1'b1;
                        fill_count_in = SCREEN_CELLS;
                        state_next    = ST_CLR_SCREEN;
                    end
                end
            end
            ST_CLR_LINE, ST_CLR_SCREEN: begin
                if (fill_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_CLR_SCREEN;
        endcase

        // Scroll by wrapping and blanking the line we land on
        if (adv) begin
            if (cursor_row == LAST_ROW) begin
                row_next  = '0;
                base_next = '0;
            end else begin
                row_next  = cursor_row + 5'd1;
                base_next = line_base + LINE_CELLS;
            end
            fill_start    = 1'b1;
            fill_base_in  = base_next;
            fill_count_in = LINE_CELLS;
            state_next    = ST_CLR_LINE;
        end
    end

    always_ff @(posedge CPUClk or posedge reset) begin
        if (reset) begin
            cursor_row <= '0;
            cursor_col <= '0;
            line_base  <= '0;
            in_ready   <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            cursor_row <= row_next;
            cursor_col <= col_next;
            line_base  <= base_next;
            in_ready   <= (state_next == ST_IDLE);
            if (wr_next) begin
                wr_en   <= 1'b1;
                wr_addr <= addr_next;
                wr_data <= data_next;
            end else if (fill_valid) begin
                wr_en   <= 1'b1;
                wr_addr <= fill_addr;
                wr_data <= BLANK;
            end else begin
                wr_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_text_console.sv
// Bench for text_console: directed scenarios plus random byte streams
// checked against a screen/cursor model built from the console rules.
module tb_text_console;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [4:0]  cursor_row;
    logic [6:0]  cursor_col;

    text_console dut (
        .CPUClk     (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int addr;
        int data;
        bit rdy;
    } wr_t;

    wr_t        wlog[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] scr[2400];
    logic [7:0] exp_scr[2400];
    int         nwrites = 0;
    int         exp_writes = 0;
    int         m_row = 0;
    int         m_col = 0;
    int         acc_edge = 0;
    int         post_row = 0;
    int         post_col = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset && wr_en === 1'b1) begin
            wr_t e;
            e.cyc  = cyc;
            e.addr = int'(wr_addr);
            e.data = int'(wr_data);
            e.rdy  = in_ready;
            if (wr_addr < 12'd2400) scr[wr_addr] = wr_data;
            nwrites++;
            wlog.push_back(e);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog sim_time=%0t required completion", $time);
        $fatal(1, "watchdog");
    end

    function automatic bit printable(input logic [7:0] c);
        return (c >= 8'h20) && (c != 8'h7F);
    endfunction

    task automatic model_advance();
        m_row = (m_row + 1) % 30;
        for (int i = 0; i < 80; i++) exp_scr[m_row * 80 + i] = 8'h20;
        exp_writes += 80;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2400; i++) exp_scr[i] = 8'h20;
        exp_writes += 2400;
        m_row = 0;
        m_col = 0;
    endtask

    task automatic model_byte(input logic [7:0] c);
        if (printable(c)) begin
            exp_scr[m_row * 80 + m_col] = c;
            exp_writes++;
            if (m_col == 79) begin
                m_col = 0;
                model_advance();
            end else begin
                m_col++;
            end
        end else if (c == 8'h0A) begin
            model_advance();
        end else if (c == 8'h0D) begin
            m_col = 0;
        end else if (c == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                exp_scr[m_row * 80 + m_col] = 8'h20;
                exp_writes++;
            end
        end else if (c == 8'h0C) begin
            model_clear();
        end
    endtask

    task automatic put_byte(input logic [7:0] c);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = c;
        while (in_ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout byte=%h in_ready=%b required 1", c, in_ready);
            in_valid = 1'b0;
            return;
        end
        acc_edge = cyc + 1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        post_row = int'(cursor_row);
        post_col = int'(cursor_col);
        model_byte(c);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_timeout in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        int n = 0;
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl in_ready=%b wr_en=%b required 0 0", in_ready, wr_en);
        end
        checks++;
        if (cursor_row !== 5'd0 || cursor_col !== 7'd0) begin
            errors++;
            $display("FAIL reset_cursor got (%0d,%0d) required (0,0)", cursor_row, cursor_col);
        end
        checks++;
        if (wr_addr !== 12'd0 || wr_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_wr got addr=%0d data=%h required 0 00", wr_addr, wr_data);
        end
        for (int i = 0; i < 2400; i++) scr[i] = 8'h00;
        wlog.delete();
        nwrites    = 0;
        exp_writes = 0;
        model_clear();
        reset = 1'b0;
        while (wr_en !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 2400; i++) begin
            if (wr_en !== 1'b1 || wr_addr !== 12'(i) || wr_data !== 8'h20 || in_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL boot_clear_stream bad_cycles=%0d required 0", bad);
        end
        checks++;
        if (in_ready !== 1'b1 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL boot_clear_end in_ready=%b wr_en=%b required 1 0", in_ready, wr_en);
        end
        checks++;
        if (cursor_row !== 5'd0 || cursor_col !== 7'd0) begin
            errors++;
            $display("FAIL boot_cursor got (%0d,%0d) required (0,0)", cursor_row, cursor_col);
        end
    endtask

    task automatic test_single();
        wlog.delete();
        put_byte(8'h41);
        wait_idle();
        checks++;
        if (wlog.size() != 1) begin
            errors++;
            $display("FAIL single_count got %0d required 1", wlog.size());
        end else begin
            checks++;
            if (wlog[0].addr != 0 || wlog[0].data != 8'h41 || wlog[0].cyc != acc_edge) begin
                errors++;
                $display("FAIL single_write got addr=%0d data=%h cyc=%0d required 0 41 %0d",
                         wlog[0].addr, wlog[0].data, wlog[0].cyc, acc_edge);
            end
        end
        checks++;
        if (post_row != 0 || post_col != 1) begin
            errors++;
            $display("FAIL single_cursor got (%0d,%0d) required (0,1)", post_row, post_col);
        end
    endtask

    task automatic test_full_line();
        int bad = 0;
        int last_acc;
        put_byte(8'h0D);
        wait_idle();
        checks++;
        if (post_col != 0 || post_row != 0) begin
            errors++;
            $display("FAIL cr_cursor got (%0d,%0d) required (0,0)", post_row, post_col);
        end
        wlog.delete();
        for (int i = 0; i < 80; i++) put_byte(8'($urandom_range(33, 126)));
        last_acc = acc_edge;
        wait_idle();
        checks++;
        if (wlog.size() != 160) begin
            errors++;
            $display("FAIL line_count got %0d required 160", wlog.size());
        end else begin
            for (int i = 0; i < 80; i++)
                if (wlog[i].addr != i || wlog[i].data != int'(exp_scr[i])) bad++;
            for (int i = 80; i < 160; i++)
                if (wlog[i].addr != i || wlog[i].data != 8'h20 || wlog[i].rdy
                    || wlog[i].cyc != last_acc + i - 79) bad++;
            checks++;
            if (bad != 0 || wlog[79].cyc != last_acc) begin
                errors++;
                $display("FAIL line_writes bad=%0d last_cyc=%0d required 0 %0d",
                         bad, wlog[79].cyc, last_acc);
            end
        end
        checks++;
        if (cursor_row !== 5'd1 || cursor_col !== 7'd0) begin
            errors++;
            $display("FAIL line_cursor got (%0d,%0d) required (1,0)", cursor_row, cursor_col);
        end
    endtask

    task automatic test_lf_wrap();
        int bad = 0;
        for (int i = 0; i < 28; i++) put_byte(8'h0A);
        for (int i = 0; i < 7; i++) put_byte(8'($urandom_range(33, 126)));
        wait_idle();
        checks++;
        if (cursor_row !== 5'd29 || cursor_col !== 7'd7) begin
            errors++;
            $display("FAIL wrap_setup got (%0d,%0d) required (29,7)", cursor_row, cursor_col);
        end
        wlog.delete();
        put_byte(8'h0A);
        wait_idle();
        for (int i = 0; i < 80; i++)
            if (i >= wlog.size() || wlog[i].addr != i || wlog[i].data != 8'h20) bad++;
        checks++;
        if (wlog.size() != 80 || bad != 0) begin
            errors++;
            $display("FAIL wrap_clear count=%0d bad=%0d required 80 0", wlog.size(), bad);
        end
        checks++;
        if (post_row != 0 || post_col != 7) begin
            errors++;
            $display("FAIL wrap_cursor got (%0d,%0d) required (0,7)", post_row, post_col);
        end
        wlog.delete();
        put_byte(8'h0D);
        wait_idle();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (wlog.size() != 0 || cursor_row !== 5'd0 || cursor_col !== 7'd0) begin
            errors++;
            $display("FAIL cr_nowrite writes=%0d cursor=(%0d,%0d) required 0 (0,0)",
                     wlog.size(), cursor_row, cursor_col);
        end
    endtask

    task automatic test_backspace();
        put_byte(8'h0A);
        put_byte(8'h0A);
        for (int i = 0; i < 5; i++) put_byte(8'($urandom_range(33, 126)));
        wait_idle();
        wlog.delete();
        put_byte(8'h08);
        wait_idle();
        checks++;
        if (wlog.size() != 1 || wlog[0].addr != 164 || wlog[0].data != 8'h20
            || wlog[0].cyc != acc_edge) begin
            errors++;
            $display("FAIL bs_write count=%0d addr=%0d data=%h cyc=%0d required 1 164 20 %0d",
                     wlog.size(), wlog[0].addr, wlog[0].data, wlog[0].cyc, acc_edge);
        end
        checks++;
        if (post_row != 2 || post_col != 4) begin
            errors++;
            $display("FAIL bs_cursor got (%0d,%0d) required (2,4)", post_row, post_col);
        end
        put_byte(8'h0D);
        wait_idle();
        wlog.delete();
        put_byte(8'h08);
        wait_idle();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (wlog.size() != 0 || cursor_row !== 5'd2 || cursor_col !== 7'd0) begin
            errors++;
            $display("FAIL bs_col0 writes=%0d cursor=(%0d,%0d) required 0 (2,0)",
                     wlog.size(), cursor_row, cursor_col);
        end
    endtask

    task automatic test_random();
        logic [7:0] others[7];
        logic [7:0] c;
        int bad = 0;
        int r;
        others = '{8'h00, 8'h01, 8'h07, 8'h09, 8'h1B, 8'h1F, 8'h7F};
        wait_idle();
        nwrites    = 0;
        exp_writes = 0;
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 99);
            if (r < 70) begin
                c = 8'($urandom_range(32, 255));
                if (c == 8'h7F) c = 8'h7E;
            end else if (r < 78) c = 8'h0A;
            else if (r < 84) c = 8'h0D;
            else if (r < 92) c = 8'h08;
            else if (r < 94) c = 8'h0C;
            else c = others[$urandom_range(0, 6)];
            repeat ($urandom_range(0, 2)) @(negedge clk);
            put_byte(c);
        end
        wait_idle();
        for (int i = 0; i < 2400; i++) if (scr[i] !== exp_scr[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL random_screen bad_cells=%0d required 0", bad);
        end
        checks++;
        if (nwrites != exp_writes) begin
            errors++;
            $display("FAIL random_write_count got %0d required %0d", nwrites, exp_writes);
        end
        checks++;
        if (cursor_row !== 5'(m_row) || cursor_col !== 7'(m_col)) begin
            errors++;
            $display("FAIL random_cursor got (%0d,%0d) required (%0d,%0d)",
                     cursor_row, cursor_col, m_row, m_col);
        end
    endtask

    task automatic test_ff_reset();
        int bad = 0;
        int n = 0;
        put_byte(8'h0A);
        put_byte(8'h51);
        put_byte(8'h0C);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (700) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || wr_en !== 1'b1) begin
            errors++;
            $display("FAIL ff_busy in_ready=%b wr_en=%b required 0 1", in_ready, wr_en);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || wr_en !== 1'b0 || cursor_col !== 7'd0) begin
            errors++;
            $display("FAIL async_reset in_ready=%b wr_en=%b col=%0d required 0 0 0",
                     in_ready, wr_en, cursor_col);
        end
        repeat (2) @(negedge clk);
        model_clear();
        wlog.delete();
        reset = 1'b0;
        while (wr_en !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 2400; i++) begin
            if (wr_en !== 1'b1 || wr_addr !== 12'(i) || wr_data !== 8'h20 || in_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL restart_clear bad_cycles=%0d required 0", bad);
        end
        checks++;
        if (in_ready !== 1'b1 || cursor_row !== 5'd0 || cursor_col !== 7'd0) begin
            errors++;
            $display("FAIL restart_end in_ready=%b cursor=(%0d,%0d) required 1 (0,0)",
                     in_ready, cursor_row, cursor_col);
        end
        acc_edge = cyc + 1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_byte(8'h5A);
        checks++;
        if (cursor_row !== 5'd0 || cursor_col !== 7'd1) begin
            errors++;
            $display("FAIL held_cursor got (%0d,%0d) required (0,1)", cursor_row, cursor_col);
        end
        wait_idle();
        checks++;
        if (wlog.size() != 2401 || wlog[2400].addr != 0 || wlog[2400].data != 8'h5A
            || wlog[2400].cyc != acc_edge) begin
            errors++;
            $display("FAIL held_write count=%0d addr=%0d data=%h required 2401 0 5a",
                     wlog.size(), wlog[wlog.size() - 1].addr, wlog[wlog.size() - 1].data);
        end
        bad = 0;
        for (int i = 0; i < 2400; i++) if (scr[i] !== exp_scr[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL final_screen bad_cells=%0d required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_line();
        test_lf_wrap();
        test_backspace();
        test_random();
        test_ff_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_console.md
Name: text_console

Overview:
- Upstream feeder of the VGA text generator: converts a CPU byte stream into writes on the write port of the dual-port character RAM (80x30 cells, address = row*80 + col).
- Maintains the cursor and handles control codes.
- Scrolls by wrap-and-clear: advancing onto a line blanks that line first.
- Runs entirely in the CPU clock domain; the character RAM's second port is read by the display side.

Parameters:
- COLS, 80, characters per row.
- ROWS, 30, rows per screen; COLS*ROWS must not exceed 4096.
- BLANK, 8'h20, fill byte used for clears and backspace.

Ports:
- CPUClk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  byte offered.
- in_data  in  8  character or control code.
- in_ready  out  1  block can accept a byte this cycle.
- wr_en  out  1  character RAM write strobe.
- wr_addr  out  12  character RAM write address.
- wr_data  out  8  character RAM write data.
- cursor_row  out  5  current row, 0..ROWS-1.
- cursor_col  out  7  current column, 0..COLS-1.

Behaviour:
- All outputs are registered.
- Reset (asynchronous):
  - cursor = (0,0), line_base = 0, wr_en = 0, wr_addr = 0, wr_data = 0, in_ready = 0.
  - State = CLR_SCREEN, fill counter = 0.
  - Reset asserted at any point, including mid-clear, aborts the current activity and restarts the full-screen clear.
- States: IDLE, CLR_LINE, CLR_SCREEN.
  - in_ready = 1 only in IDLE.
  - A byte is accepted on an edge where in_valid && in_ready.
- Address arithmetic:
  - No multiplier. line_base holds row*COLS; it is incremented by COLS on line advance and reset to 0 on wrap.
  - wr_addr = line_base + col.
- Write latency: wr_en/wr_addr/wr_data are asserted the cycle after acceptance, for exactly one cycle per write.
- Printable bytes (0x20-0x7E, 0x80-0xFF):
  - Write the byte at the cursor, then col+1.
  - If col was COLS-1: col = 0 and perform a line advance.
- 0x0A (LF): line advance; col is unchanged.
- 0x0D (CR): col = 0; no write.
- 0x08 (BS):
  - If col > 0: col-1, and write BLANK at the new position.
  - If col == 0: no-op; the byte is consumed and there is no write.
- 0x0C (FF): cursor = (0,0), line_base = 0, then CLR_SCREEN.
- All other bytes (0x00-0x1F not listed, 0x7F): consumed silently, no write, cursor unchanged.
- Line advance:
  - row+1, line_base += COLS. If row was ROWS-1: row = 0, line_base = 0.
  - Then enter CLR_LINE.
  - When a printable byte in the last column also advances, the character write occurs first, and the CLR_LINE writes begin the following cycle.
- CLR_LINE:
  - COLS consecutive write cycles, addresses line_base .. line_base+COLS-1, data BLANK.
  - Returns to IDLE after the last write; in_ready = 1 the cycle after the final wr_en.
- CLR_SCREEN:
  - COLS*ROWS consecutive writes, addresses 0 .. COLS*ROWS-1, data BLANK.
  - Then IDLE, with in_ready behaving as for CLR_LINE.
- in_valid held while in_ready = 0: the byte is not consumed and in_data must be held.
- Cursor outputs update on the acceptance edge, so they reflect the post-byte position.

Decomposition:
- Shared package:
  - COLS, ROWS, BLANK.
  - Control-code constants CH_LF, CH_CR, CH_BS, CH_FF.
  - State encoding for IDLE / CLR_LINE / CLR_SCREEN.
- One natural sub-module, blank_filler:
  - Inputs: start pulse, base address, count.
  - Emits a stream of BLANK writes and a done pulse.
  - Shared by CLR_LINE and CLR_SCREEN.

Test Plan:
- Reset release -> 2400 consecutive writes of 0x20 to addresses 0..2399, then in_ready rises; cursor (0,0).
- Send 0x41 at (0,0) -> one write, addr 0, data 0x41, the cycle after acceptance; cursor (0,1).
- Send 80 printable bytes from (0,0):
  - Last write is addr 79.
  - Then 80 blank writes to 80..159 with in_ready low.
  - Cursor ends at (1,0).
- Send LF at row 29, col 7 -> blank writes to 0..79; cursor (0,7). Then CR -> no write; cursor (0,0).
- Send BS at (2,5) -> write 0x20 to addr 164; cursor (2,4). BS at (2,0) -> no write; cursor unchanged.
- Send FF mid-screen, then assert reset during the resulting clear -> clear restarts from addr 0 and completes all 2400 writes before in_ready = 1; an in_valid held throughout is accepted only afterward.
